// File: rtl/sobel_window_stream.sv
// Streaming 3x3 window generator: raster pixels in, one bordered window per frame pixel out.
// Two previous lines live in a single line-buffer RAM whose word packs {row r-2, row r-1}.
module sobel_window_stream #(
    parameter int DW     = 8,
    parameter int WIDTH  = 128,
    parameter int HEIGHT = 96
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            border_mode,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_sof,
    input  logic [DW-1:0]   in_data,
    output logic            out_valid,
    output logic [9*DW-1:0] out_win,
    output logic            out_sof,
    output logic            out_eol,
    output logic            out_eof,
    output logic            frame_err
);
    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    logic [1:0]    state_q, state_d;
    logic          mode_q, mode_d;
    logic [CW-1:0] in_col_q, in_col_d, col_base, cen_col_q, cen_col_d;
    logic [RW-1:0] in_row_q, in_row_d, row_base, cen_row_q, cen_row_d;
    logic [2*DW-1:0] lb_mem [WIDTH];
    logic [2*DW-1:0] lb_rd_q;
    logic [2:0][1:0][DW-1:0] sr_q, sr_d;
    logic [2:0][2:0][DW-1:0] w;
    logic [2:0][DW-1:0]      new_col;
    logic [1:0]    rsel [3];
    logic [1:0]    csel [3];
    logic [9*DW-1:0] win, out_win_d;
    logic [DW-1:0] pix;
    logic accept, step, emit, new_frame, err, cen_last;
    logic out_valid_d, out_sof_d, out_eol_d, out_eof_d, frame_err_d;

    assign in_ready = (state_q != S_FLUSH);
    assign accept   = in_valid && in_ready;
    assign cen_last = (cen_col_q == COL_LAST) && (cen_row_q == ROW_LAST);

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        step      = 1'b0;
        emit      = 1'b0;
        new_frame = 1'b0;
        err       = 1'b0;
        pix       = in_data;
        case (state_q)
            S_IDLE: if (accept && in_sof) new_frame = 1'b1;
            S_FILL, S_RUN: begin
                if (accept) begin
                    if (in_sof) begin
                        new_frame = 1'b1;
                        err       = 1'b1;
                    end else begin
                        step = 1'b1;
                        // Pixel (1,1) completes the first window's bottom-right tap
                        if (state_q == S_RUN || (in_row_q == ROW_ONE && in_col_q == COL_ONE)) begin
                            emit    = 1'b1;
                            state_d = S_RUN;
                        end
                        if (state_q == S_RUN && in_row_q == ROW_LAST && in_col_q == COL_LAST)
                            state_d = S_FLUSH;
                    end
                end
            end
            default: begin
                // Flush pushes dummy pixels; every tap they touch lies outside the frame
                step = 1'b1;
                emit = 1'b1;
                pix  = '0;
                if (cen_last) state_d = S_IDLE;
            end
        endcase
        if (new_frame) begin
            step    = 1'b1;
            state_d = S_FILL;
            mode_d  = border_mode;
        end

        col_base = new_frame ? '0 : in_col_q;
        row_base = new_frame ? '0 : in_row_q;
        in_col_d = in_col_q;
        in_row_d = in_row_q;
        if (step) begin
            in_col_d = (col_base == COL_LAST) ? '0 : col_base + COL_ONE;
            in_row_d = row_base;
            if (col_base == COL_LAST) in_row_d = (row_base == ROW_LAST) ? '0 : row_base + ROW_ONE;
        end

        cen_col_d = cen_col_q;
        cen_row_d = cen_row_q;
        if (new_frame) begin
            cen_col_d = '0;
            cen_row_d = '0;
        end else if (emit) begin
            cen_col_d = (cen_col_q == COL_LAST) ? '0 : cen_col_q + COL_ONE;
            if (cen_col_q == COL_LAST) cen_row_d = (cen_row_q == ROW_LAST) ? '0 : cen_row_q + ROW_ONE;
        end

        new_col[0] = lb_rd_q[2*DW-1:DW];
        new_col[1] = lb_rd_q[DW-1:0];
        new_col[2] = pix;
        for (int i = 0; i < 3; i++) begin
            w[i][0]    = sr_q[i][0];
            w[i][1]    = sr_q[i][1];
            w[i][2]    = new_col[i];
            sr_d[i][0] = step ? sr_q[i][1] : sr_q[i][0];
            sr_d[i][1] = step ? new_col[i] : sr_q[i][1];
        end

        // Out-of-frame taps redirect to the centre row/column, which is the clamped edge
        rsel[0] = (cen_row_q == '0) ? 2'd1 : 2'd0;
        rsel[1] = 2'd1;
        rsel[2] = (cen_row_q == ROW_LAST) ? 2'd1 : 2'd2;
        csel[0] = (cen_col_q == '0) ? 2'd1 : 2'd0;
        csel[1] = 2'd1;
        csel[2] = (cen_col_q == COL_LAST) ? 2'd1 : 2'd2;

        out_valid_d = emit;
        out_win_d   = emit ? win : out_win;
        out_sof_d   = emit && cen_col_q == '0 && cen_row_q == '0;
        out_eol_d   = emit && cen_col_q == COL_LAST;
        out_eof_d   = emit && cen_last;
        frame_err_d = err;
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_row
        for (genvar gj = 0; gj < 3; gj++) begin : g_col
            assign win[(gi*3+gj)*DW +: DW] =
                (!mode_q && (rsel[gi] != 2'(gi) || csel[gj] != 2'(gj))) ? '0 : w[rsel[gi]][csel[gj]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mode_q    <= 1'b0;
            in_col_q  <= '0;
            in_row_q  <= '0;
            cen_col_q <= '0;
            cen_row_q <= '0;
            out_valid <= 1'b0;
            out_win   <= '0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            in_col_q  <= in_col_d;
            in_row_q  <= in_row_d;
            cen_col_q <= cen_col_d;
            cen_row_q <= cen_row_d;
            out_valid <= out_valid_d;
            out_win   <= out_win_d;
            out_sof   <= out_sof_d;
            out_eol   <= out_eol_d;
            out_eof   <= out_eof_d;
            frame_err <= frame_err_d;
        end
    end

    // Read address tracks the next pixel's column, so read and write never collide
    always_ff @(posedge clk) begin
        if (step) lb_mem[col_base] <= {lb_rd_q[DW-1:0], pix};
        lb_rd_q <= lb_mem[in_col_d];
        sr_q    <= sr_d;
    end
endmodule

// File: tb/tb_sobel_window_stream.sv
// Directed bench for sobel_window_stream on a 4x3 frame.
module tb_sobel_window_stream;
    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int N  = W * H;

    logic        clk = 1'b0;
    logic        rst, border_mode, in_valid, in_ready, in_sof;
    logic [7:0]  in_data;
    logic        out_valid, out_sof, out_eol, out_eof, frame_err;
    logic [71:0] out_win;

    int checks = 0;
    int passes = 0;
    logic [71:0] wins  [N];
    logic [71:0] wins1 [N];
    logic [7:0]  fr    [N];

    sobel_window_stream #(.DW(DW), .WIDTH(W), .HEIGHT(H)) dut (
        .clk(clk), .rst(rst), .border_mode(border_mode),
        .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_data(in_data),
        .out_valid(out_valid), .out_win(out_win), .out_sof(out_sof),
        .out_eol(out_eol), .out_eof(out_eof), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [71:0] ref_win(input int idx, input logic m);
        logic [71:0] v;
        int cr, cc, r, c;
        logic oob;
        v  = '0;
        cr = idx / W;
        cc = idx % W;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                r   = cr + i - 1;
                c   = cc + j - 1;
                oob = (r < 0) || (r >= H) || (c < 0) || (c >= W);
                if (r < 0) r = 0;
                if (r >= H) r = H - 1;
                if (c < 0) c = 0;
                if (c >= W) c = W - 1;
                v[(i*3+j)*8 +: 8] = (oob && !m) ? 8'd0 : fr[r*W+c];
            end
        end
        return v;
    endfunction

    task automatic check_out(input int idx, input logic m);
        chk($sformatf("valid[%0d]", idx), out_valid, 1);
        chk($sformatf("win[%0d]", idx), out_win, ref_win(idx, m));
        chk($sformatf("sof[%0d]", idx), out_sof, idx == 0);
        chk($sformatf("eol[%0d]", idx), out_eol, idx % W == W - 1);
        chk($sformatf("eof[%0d]", idx), out_eof, idx == N - 1);
        wins[idx] = out_win;
    endtask

    task automatic run_frame(input logic m, input logic [7:0] base, input logic gap, input logic exp_err);
        int nlow;
        for (int k = 0; k < N; k++) fr[k] = base + 8'(k);
        border_mode = m;
        for (int k = 0; k < N; k++) begin
            if (gap) begin
                in_valid = 1'b0;
                in_sof   = 1'b0;
                tick();
                chk("gap_no_valid", out_valid, 0);
            end
            in_valid = 1'b1;
            in_sof   = (k == 0);
            in_data  = fr[k];
            chk("ready_in_frame", in_ready, 1);
            tick();
            chk("frame_err", frame_err, (k == 0) && exp_err);
            if (k >= W + 1) check_out(k - W - 1, m);
            else chk("fill_no_valid", out_valid, 0);
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
        nlow     = 0;
        while (!in_ready && nlow < 8) begin
            tick();
            if (nlow < W + 1) check_out(N - W - 1 + nlow, m);
            nlow++;
        end
        chk("flush_len", nlow, W + 1);
        chk("ready_after", in_ready, 1);
        tick();
        chk("idle_no_valid", out_valid, 0);
    endtask

    initial begin
        rst = 1'b1; border_mode = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
        tick();
        tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_win", out_win, 0);
        chk("rst_flags", {out_sof, out_eol, out_eof, frame_err}, 0);
        chk("rst_ready", in_ready, 1);
        rst = 1'b0;
        tick();

        // Test 1: zero border ramp
        run_frame(1'b0, 8'd0, 1'b0, 1'b0);
        chk("t1_first", wins[0], {8'd5, 8'd4, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0});
        chk("t1_last_p4", wins[N-1][39:32], 11);
        chk("t1_last_p8", wins[N-1][71:64], 0);
        for (int i = 0; i < N; i++) wins1[i] = wins[i];

        // Test 2: replicate border ramp
        run_frame(1'b1, 8'd0, 1'b0, 1'b0);
        chk("t2_first", wins[0], {8'd5, 8'd4, 8'd4, 8'd1, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0});
        chk("t2_win_1_3", wins[7], {8'd11, 8'd11, 8'd10, 8'd7, 8'd7, 8'd6, 8'd3, 8'd3, 8'd2});

        // Test 3: input valid every other cycle
        run_frame(1'b0, 8'd0, 1'b1, 1'b0);
        for (int i = 0; i < N; i++) chk($sformatf("t3_same[%0d]", i), wins[i], wins1[i]);

        // Test 4: SOF re-asserted at k=6
        border_mode = 1'b0;
        for (int k = 0; k < N; k++) fr[k] = 8'(k);
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_sof   = (k == 0);
            in_data  = fr[k];
            tick();
            if (k == 5) check_out(0, 1'b0);
            else chk("t4_fill", out_valid, 0);
        end
        run_frame(1'b0, 8'd100, 1'b0, 1'b1);

        // Test 5: reset during RUN, then pixels without SOF are ignored
        border_mode = 1'b0;
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_sof   = (k == 0);
            in_data  = 8'(k);
            tick();
        end
        chk("t5_running", out_valid, 1);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        rst      = 1'b1;
        tick();
        chk("t5_rst_valid", out_valid, 0);
        chk("t5_rst_ready", in_ready, 1);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_data  = 8'(k + 40);
            tick();
            chk("t5_dropped", out_valid, 0);
        end
        in_valid = 1'b0;
        tick();
        chk("t5_no_err", frame_err, 0);
        run_frame(1'b1, 8'd50, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
